// File: rtl/buf_scan_if.sv
// Frame-buffer side of the scan controller: full flags, read data,
// read enables, shared read address and buffer-empty handshake.
interface buf_scan_if;
  logic        Buffer0Full;
  logic        Buffer1Full;
  logic [7:0]  R0;
  logic [7:0]  G0;
  logic [7:0]  B0;
  logic [7:0]  R1;
  logic [7:0]  G1;
  logic [7:0]  B1;
  logic        RE0;
  logic        RE1;
  logic [19:0] Addr;
  logic        Buf0Empty;
  logic        Buf1Empty;

  // Scan controller side
  modport master (
    input  Buffer0Full, Buffer1Full, R0, G0, B0, R1, G1, B1,
    output RE0, RE1, Addr, Buf0Empty, Buf1Empty
  );

  // Frame buffer / upstream side
  modport slave (
    output Buffer0Full, Buffer1Full, R0, G0, B0, R1, G1, B1,
    input  RE0, RE1, Addr, Buf0Empty, Buf1Empty
  );
endinterface

// File: rtl/buf_scan_ctrl.sv
// Double-buffered display scan controller. Picks a full frame buffer,
// raster-scans it with horizontal/vertical blanking, then hands the buffer
// back to upstream. Define SCAN_REPEAT_EN to re-display the current buffer
// when no other buffer is ready at frame end instead of idling.
module buf_scan_ctrl #(
  parameter int unsigned H_ACTIVE = 100,
  parameter int unsigned V_ACTIVE = 100,
  parameter int unsigned H_BLANK  = 4,
  parameter int unsigned V_BLANK  = 2
) (
  input  logic             clk,
  input  logic             reset,
  buf_scan_if.master       bus,
  output logic [7:0]       Rout,
  output logic [7:0]       Gout,
  output logic [7:0]       Bout,
  output logic             PixValid,
  output logic             HSync,
  output logic             VSync,
  output logic             FrameDone
);

  localparam int unsigned AW       = 20;
  localparam int unsigned LINE_LEN = H_ACTIVE + H_BLANK;
  localparam int unsigned VB_LEN   = V_BLANK * LINE_LEN;
  localparam int unsigned XW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned CNT_MAX  = (VB_LEN > H_BLANK) ? VB_LEN : H_BLANK;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  state_t          state_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      re_q;
  logic [1:0]      empty_q;
  logic            sel_q;
  logic            last_q;
  logic            pix_valid_q;
  logic            hsync_q;
  logic            vsync_q;
  logic            frame_done_q;
`ifdef SCAN_REPEAT_EN
  logic            released_q;
`endif

  logic            other_full_c;
  logic            start_c;
  logic            start_buf_c;

  assign other_full_c = sel_q ? bus.Buffer0Full : bus.Buffer1Full;

  // Frame-start decision: from IDLE on any full buffer, or at the end of VBLANK
  always_comb begin
    start_c     = 1'b0;
    start_buf_c = sel_q;
    case (state_q)
      IDLE: begin
        start_c = bus.Buffer0Full | bus.Buffer1Full;
        if (bus.Buffer0Full & bus.Buffer1Full) start_buf_c = ~last_q;
        else                                   start_buf_c = bus.Buffer1Full;
      end
      VBLANK: begin
        if (cnt_q == CW'(VB_LEN - 1)) begin
`ifdef SCAN_REPEAT_EN
          if (!released_q) begin
            start_c     = 1'b1;
            start_buf_c = sel_q;
          end else
`endif
          if (other_full_c) begin
            start_c     = 1'b1;
            start_buf_c = ~sel_q;
          end
        end
      end
      default: ;
    endcase
  end

  // Scan FSM, counters, buffer handshake and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      re_q         <= 2'b00;
      empty_q      <= 2'b11;
      sel_q        <= 1'b0;
      last_q       <= 1'b1;
      pix_valid_q  <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SCAN_REPEAT_EN
      released_q   <= 1'b0;
`endif
    end else begin
      pix_valid_q  <= |re_q;
      frame_done_q <= 1'b0;
      case (state_q)
        ACTIVE: begin
          if (x_q != XW'(H_ACTIVE - 1)) begin
            x_q    <= x_q + XW'(1);
            addr_q <= addr_q + AW'(1);
          end else begin
            re_q    <= 2'b00;
            hsync_q <= 1'b1;
            cnt_q   <= '0;
            if (y_q != YW'(V_ACTIVE - 1)) begin
              state_q <= HBLANK;
            end else begin
              state_q <= VBLANK;
              vsync_q <= 1'b1;
            end
          end
        end
        HBLANK: begin
          if (cnt_q == CW'(H_BLANK - 1)) begin
            state_q <= ACTIVE;
            hsync_q <= 1'b0;
            x_q     <= '0;
            y_q     <= y_q + YW'(1);
            addr_q  <= addr_q + AW'(1);
            re_q    <= sel_q ? 2'b10 : 2'b01;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        VBLANK: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == '0) frame_done_q <= 1'b1;
          // Hand the buffer back during the last blanking cycle
          if (cnt_q == CW'(VB_LEN - 2)) begin
`ifdef SCAN_REPEAT_EN
            released_q <= other_full_c;
            if (other_full_c) empty_q[sel_q] <= 1'b1;
`else
            empty_q[sel_q] <= 1'b1;
`endif
          end
          if (cnt_q == CW'(VB_LEN - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
          end
        end
        default: ;
      endcase
      if (start_c) begin
        state_q              <= ACTIVE;
        sel_q                <= start_buf_c;
        last_q               <= start_buf_c;
        x_q                  <= '0;
        y_q                  <= '0;
        addr_q               <= '0;
        re_q                 <= start_buf_c ? 2'b10 : 2'b01;
        empty_q[start_buf_c] <= 1'b0;
      end
    end
  end

  assign bus.RE0       = re_q[0];
  assign bus.RE1       = re_q[1];
  assign bus.Addr      = addr_q;
  assign bus.Buf0Empty = empty_q[0];
  assign bus.Buf1Empty = empty_q[1];

  // Read data arrives one cycle after RE, so it is steered straight through
  assign Rout      = pix_valid_q ? (sel_q ? bus.R1 : bus.R0) : 8'h00;
  assign Gout      = pix_valid_q ? (sel_q ? bus.G1 : bus.G0) : 8'h00;
  assign Bout      = pix_valid_q ? (sel_q ? bus.B1 : bus.B0) : 8'h00;
  assign PixValid  = pix_valid_q;
  assign HSync     = hsync_q;
  assign VSync     = vsync_q;
  assign FrameDone = frame_done_q;

endmodule

// File: tb/tb_buf_scan_ctrl.sv
// Directed bench for buf_scan_ctrl with default 100x100 geometry and a
// one-cycle-latency frame buffer model for each buffer.
module tb_buf_scan_ctrl;

  localparam int unsigned NPIX   = 10000;
  localparam int unsigned VB_CYC = 208;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Rout, Gout, Bout;
  logic       PixValid, HSync, VSync, FrameDone;

  int checks = 0;
  int errors = 0;

  buf_scan_if bif();

  buf_scan_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .Rout      (Rout),
    .Gout      (Gout),
    .Bout      (Bout),
    .PixValid  (PixValid),
    .HSync     (HSync),
    .VSync     (VSync),
    .FrameDone (FrameDone)
  );

  always #5 clk = ~clk;

  // Buffer contents, packed {B,G,R}
  function automatic logic [23:0] word0(input logic [19:0] a);
    if (a == 20'd0) return 24'h112233;
    return {a[7:0] ^ 8'h5A, a[15:8], a[7:0]};
  endfunction

  function automatic logic [23:0] word1(input logic [19:0] a);
    return {a[7:0], a[7:0] ^ 8'hC3, {4'h9, a[19:16]}};
  endfunction

  // Frame buffer read ports with one cycle of latency
  always @(posedge clk) begin
    if (bif.RE0) {bif.B0, bif.G0, bif.R0} <= word0(bif.Addr);
    if (bif.RE1) {bif.B1, bif.G1, bif.R1} <= word1(bif.Addr);
  end

  task automatic test_reset();
    reset = 1'b0;
    bif.Buffer0Full = 1'b0;
    bif.Buffer1Full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bif.RE1, bif.RE0, PixValid, HSync, VSync, FrameDone, bif.Buf1Empty, bif.Buf0Empty} !== 8'b0000_0011
          || bif.Addr !== 20'd0 || {Rout, Gout, Bout} !== 24'd0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got re=%b%b pv=%b hs=%b vs=%b fd=%b empty=%b%b addr=%0d want re=00 pv=0 hs=0 vs=0 fd=0 empty=11 addr=0",
                 i, bif.RE1, bif.RE0, PixValid, HSync, VSync, FrameDone, bif.Buf1Empty, bif.Buf0Empty, bif.Addr);
      end
    end
  endtask

  task automatic test_first_pixel();
    bif.Buffer0Full = 1'b1;
    @(negedge clk);
    checks++;
    if ({bif.RE1, bif.RE0, bif.Buf1Empty, bif.Buf0Empty, PixValid} !== 5'b01_10_0 || bif.Addr !== 20'd0) begin
      errors++;
      $display("FAIL first_select got re=%b%b empty=%b%b pv=%b addr=%0d want re=01 empty=10 pv=0 addr=0",
               bif.RE1, bif.RE0, bif.Buf1Empty, bif.Buf0Empty, PixValid, bif.Addr);
    end
    @(negedge clk);
    checks++;
    if (PixValid !== 1'b1 || Rout !== 8'h33 || Gout !== 8'h22 || Bout !== 8'h11 || bif.Addr !== 20'd1) begin
      errors++;
      $display("FAIL first_pixel got pv=%b rgb=%h/%h/%h addr=%0d want pv=1 rgb=33/22/11 addr=1",
               PixValid, Rout, Gout, Bout, bif.Addr);
    end
  endtask

  // Continues the frame started by test_first_pixel through its VBLANK
  task automatic test_full_frame();
    int pv_cnt = 1, re_cnt = 2, gaps = 0, hb_cyc = 0, vs_cnt = 0, fd_cnt = 0, fd_pos = 0;
    int bad_pix = 0, bad_addr = 0, bad_re1 = 0;
    logic prev_re = 1'b1, prev_hb = 1'b0, last_empty = 1'b0, pre_last_empty = 1'b1;
    logic [19:0] prev_addr = 20'd1, last_re_addr = 20'd1;
    bit done = 0;
    bif.Buffer1Full = 1'b1;
    for (int i = 0; i < 12000 && !done; i++) begin
      @(negedge clk);
      if (vs_cnt > 0 && !VSync) begin
        done = 1;
      end else begin
        if (PixValid) begin
          pv_cnt++;
          if (!prev_re || {Bout, Gout, Rout} !== word0(prev_addr)) bad_pix++;
        end
        if (bif.RE1) bad_re1++;
        if (bif.RE0) begin
          re_cnt++;
          if (bif.Addr !== last_re_addr + 20'd1) bad_addr++;
          last_re_addr = bif.Addr;
        end
        if (HSync && !VSync) begin
          hb_cyc++;
          if (!prev_hb) gaps++;
        end
        if (VSync) begin
          vs_cnt++;
          if (vs_cnt == int'(VB_CYC) - 1) pre_last_empty = bif.Buf0Empty;
          last_empty = bif.Buf0Empty;
        end
        if (FrameDone) begin
          fd_cnt++;
          fd_pos = vs_cnt;
        end
        prev_re = bif.RE0;
        prev_addr = bif.Addr;
        prev_hb = HSync && !VSync;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL frame_timeout got no VBLANK end want end within 12000 cycles"); end
    checks++;
    if (pv_cnt != int'(NPIX)) begin errors++; $display("FAIL frame_pixvalid got %0d want %0d", pv_cnt, NPIX); end
    checks++;
    if (re_cnt != int'(NPIX) || last_re_addr !== 20'd9999 || bad_addr != 0) begin
      errors++;
      $display("FAIL frame_addr got reads=%0d last=%0d nonseq=%0d want reads=10000 last=9999 nonseq=0", re_cnt, last_re_addr, bad_addr);
    end
    checks++;
    if (bad_pix != 0 || bad_re1 != 0) begin
      errors++;
      $display("FAIL frame_data got bad_pix=%0d re1_cycles=%0d want 0 0", bad_pix, bad_re1);
    end
    checks++;
    if (gaps != 99 || hb_cyc != 396) begin
      errors++;
      $display("FAIL frame_hblank got gaps=%0d cycles=%0d want gaps=99 cycles=396", gaps, hb_cyc);
    end
    checks++;
    if (vs_cnt != int'(VB_CYC)) begin errors++; $display("FAIL frame_vblank got %0d want %0d", vs_cnt, VB_CYC); end
    checks++;
    if (fd_cnt != 1 || fd_pos != 2) begin
      errors++;
      $display("FAIL frame_done got pulses=%0d at_vblank_cycle=%0d want 1 at 2", fd_cnt, fd_pos);
    end
    checks++;
    if (pre_last_empty !== 1'b0 || last_empty !== 1'b1) begin
      errors++;
      $display("FAIL frame_release got empty0 prev=%b last=%b want prev=0 last=1", pre_last_empty, last_empty);
    end
  endtask

  // Called on the first cycle after buffer 0's VBLANK with both buffers full
  task automatic test_switch_buffer();
    checks++;
    if ({bif.RE1, bif.RE0, bif.Buf1Empty, bif.Buf0Empty, HSync, VSync, PixValid} !== 7'b10_01_00_0 || bif.Addr !== 20'd0) begin
      errors++;
      $display("FAIL switch_select got re=%b%b empty=%b%b hs=%b vs=%b pv=%b addr=%0d want re=10 empty=01 hs=0 vs=0 pv=0 addr=0",
               bif.RE1, bif.RE0, bif.Buf1Empty, bif.Buf0Empty, HSync, VSync, PixValid, bif.Addr);
    end
    bif.Buffer0Full = 1'b0;
    @(negedge clk);
    checks++;
    if (PixValid !== 1'b1 || {Bout, Gout, Rout} !== word1(20'd0) || bif.Addr !== 20'd1) begin
      errors++;
      $display("FAIL switch_pixel got pv=%b bgr=%h addr=%0d want pv=1 bgr=%h addr=1",
               PixValid, {Bout, Gout, Rout}, bif.Addr, word1(20'd0));
    end
  endtask

  // Buffer 1 on screen, buffer 0 not full at frame end
  task automatic test_single_full();
    bit seen = 0, done = 0;
    int empty_cyc = 0;
    for (int i = 0; i < 12000 && !done; i++) begin
      @(negedge clk);
      if (VSync && !seen) begin
        seen = 1;
        bif.Buffer1Full = 1'b0;
      end
      if (seen && !VSync) done = 1;
      else if (seen && bif.Buf1Empty) empty_cyc++;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL single_timeout got no VBLANK end want end within 12000 cycles"); end
`ifdef SCAN_REPEAT_EN
    checks++;
    if (empty_cyc != 0 || {bif.RE1, bif.RE0, bif.Buf1Empty, bif.Buf0Empty} !== 4'b10_01 || bif.Addr !== 20'd0) begin
      errors++;
      $display("FAIL repeat_select got empty1_cycles=%0d re=%b%b empty=%b%b addr=%0d want 0 re=10 empty=01 addr=0",
               empty_cyc, bif.RE1, bif.RE0, bif.Buf1Empty, bif.Buf0Empty, bif.Addr);
    end
    @(negedge clk);
    checks++;
    if (PixValid !== 1'b1 || {Bout, Gout, Rout} !== word1(20'd0) || bif.Addr !== 20'd1) begin
      errors++;
      $display("FAIL repeat_pixel got pv=%b bgr=%h addr=%0d want pv=1 bgr=%h addr=1",
               PixValid, {Bout, Gout, Rout}, bif.Addr, word1(20'd0));
    end
`else
    checks++;
    if (empty_cyc != 1 || {bif.RE1, bif.RE0, bif.Buf1Empty, bif.Buf0Empty, PixValid} !== 5'b00_11_0 || bif.Addr !== 20'd9999) begin
      errors++;
      $display("FAIL idle_release got empty1_cycles=%0d re=%b%b empty=%b%b pv=%b addr=%0d want 1 re=00 empty=11 pv=0 addr=9999",
               empty_cyc, bif.RE1, bif.RE0, bif.Buf1Empty, bif.Buf0Empty, PixValid, bif.Addr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({bif.RE1, bif.RE0, bif.Buf1Empty, bif.Buf0Empty, HSync, VSync} !== 6'b00_11_00) begin
      errors++;
      $display("FAIL idle_hold got re=%b%b empty=%b%b hs=%b vs=%b want re=00 empty=11 hs=0 vs=0",
               bif.RE1, bif.RE0, bif.Buf1Empty, bif.Buf0Empty, HSync, VSync);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    bit hit = 0;
    bif.Buffer0Full = 1'b1;
    for (int i = 0; i < 8000 && !hit; i++) begin
      @(negedge clk);
      if ((bif.RE0 || bif.RE1) && bif.Addr == 20'd5000) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL midreset_timeout got Addr never 5000 want 5000 within 8000 cycles"); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bif.RE1, bif.RE0, PixValid, HSync, VSync, FrameDone, bif.Buf1Empty, bif.Buf0Empty} !== 8'b0000_0011
        || bif.Addr !== 20'd0 || {Rout, Gout, Bout} !== 24'd0) begin
      errors++;
      $display("FAIL midreset_outputs got re=%b%b pv=%b hs=%b vs=%b fd=%b empty=%b%b addr=%0d rgb=%h want re=00 pv=0 hs=0 vs=0 fd=0 empty=11 addr=0 rgb=0",
               bif.RE1, bif.RE0, PixValid, HSync, VSync, FrameDone, bif.Buf1Empty, bif.Buf0Empty, bif.Addr, {Rout, Gout, Bout});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bif.RE1, bif.RE0, bif.Buf1Empty, bif.Buf0Empty} !== 4'b01_10 || bif.Addr !== 20'd0) begin
      errors++;
      $display("FAIL midreset_restart got re=%b%b empty=%b%b addr=%0d want re=01 empty=10 addr=0",
               bif.RE1, bif.RE0, bif.Buf1Empty, bif.Buf0Empty, bif.Addr);
    end
    @(negedge clk);
    checks++;
    if (PixValid !== 1'b1 || {Bout, Gout, Rout} !== 24'h112233 || bif.Addr !== 20'd1) begin
      errors++;
      $display("FAIL midreset_pixel got pv=%b bgr=%h addr=%0d want pv=1 bgr=112233 addr=1",
               PixValid, {Bout, Gout, Rout}, bif.Addr);
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_full_frame();
    test_switch_buffer();
    test_single_full();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
